// File: rtl/ahb_slave_mem_bridge.sv
// AHB-Lite slave to memory-request bridge: posted-write FIFO, stalled reads.
// Optional macro AHB_SLV_ALIGN_ERR_EN enables ERROR responses for misaligned or oversized transfers.
module ahb_slave_mem_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WBUF_DEPTH = 2
) (
  input  logic                      i_clk_ahb,
  input  logic                      i_rstn_ahb,
  input  logic                      i_hselx,
  input  logic                      i_hready,
  input  logic [1:0]                i_htrans,
  input  logic [2:0]                i_hsize,
  input  logic                      i_hwrite,
  input  logic [ADDR_WIDTH-1:0]     i_haddr,
  input  logic [DATA_WIDTH-1:0]     i_hwdata,
  output logic                      o_hreadyout,
  output logic                      o_hresp,
  output logic [DATA_WIDTH-1:0]     o_hrdata,
  output logic                      o_valid,
  output logic                      o_rd0_wr1,
  output logic [ADDR_WIDTH-1:0]     o_addr,
  output logic [DATA_WIDTH-1:0]     o_wr_data,
  output logic [DATA_WIDTH/8-1:0]   o_wr_strb,
  input  logic                      i_ready,
  input  logic                      i_rd_valid,
  input  logic [DATA_WIDTH-1:0]     i_rd_data
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PW   = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW   = $clog2(WBUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RD_DRAIN, RD_REQ, RD_WAIT} state_t;

  state_t state, next_state;

  logic                  accept, addr_err, read_accept;
  logic [NB-1:0]         strb_calc;
  logic                  wr_pend, err1, err2;
  logic [ADDR_WIDTH-1:0] dp_addr;
  logic [NB-1:0]         dp_strb;

  logic [ADDR_WIDTH-1:0] fifo_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [WBUF_DEPTH];
  logic [NB-1:0]         fifo_strb [WBUF_DEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         count, count_next;
  logic                  full, push, pop;

  logic unused_ok;
  assign unused_ok = i_htrans[0];

  assign accept      = i_hselx & i_hready & i_htrans[1];
  assign read_accept = accept & ~i_hwrite & ~addr_err;

  // Byte lanes covered by the transfer; lanes past the bus width fall off.
  always_comb begin
    strb_calc = '0;
    for (int i = 0; i < NB; i++) begin
      if ((i >= int'(i_haddr[OFFW-1:0])) && (i < int'(i_haddr[OFFW-1:0]) + (1 << i_hsize)))
        strb_calc[i] = 1'b1;
    end
  end

`ifdef AHB_SLV_ALIGN_ERR_EN
  always_comb begin
    addr_err = 1'b0;
    if (int'(i_hsize) > OFFW)
      addr_err = 1'b1;
    else if ((i_haddr[OFFW-1:0] & OFFW'((1 << i_hsize) - 1)) != '0)
      addr_err = 1'b1;
  end
`else
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      wr_pend <= 1'b0;
      err1    <= 1'b0;
      err2    <= 1'b0;
      dp_addr <= '0;
      dp_strb <= '0;
    end else begin
      err1 <= accept & addr_err;
      err2 <= err1;
      if (i_hready) begin
        wr_pend <= accept & i_hwrite & ~addr_err;
        if (accept) begin
          dp_addr <= {i_haddr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
          dp_strb <= strb_calc;
        end
      end
    end
  end

  // A full FIFO still accepts the push when its head pops in the same cycle.
  assign full       = (count == CW'(WBUF_DEPTH));
  assign pop        = (count != '0) & i_ready;
  assign push       = wr_pend & (~full | pop);
  assign count_next = count + CW'(push) - CW'(pop);

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      count <= count_next;
      if (push) wptr <= (wptr == PW'(WBUF_DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == PW'(WBUF_DEPTH - 1)) ? '0 : rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk_ahb) begin
    if (push) begin
      fifo_addr[wptr] <= dp_addr;
      fifo_data[wptr] <= i_hwdata;
      fifo_strb[wptr] <= dp_strb;
    end
  end

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) state <= IDLE;
    else             state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (read_accept) next_state = (count_next != '0) ? RD_DRAIN : RD_REQ;
      RD_DRAIN: if (count_next == '0) next_state = RD_REQ;
      RD_REQ:   if (i_ready) next_state = RD_WAIT;
      RD_WAIT:  if (i_rd_valid) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Bus-side response; read data is passed straight through on its return cycle.
  always_comb begin
    o_hreadyout = 1'b1;
    o_hresp     = err1 | err2;
    o_hrdata    = '0;
    if (err1) o_hreadyout = 1'b0;
    if (wr_pend && full && !pop) o_hreadyout = 1'b0;
    case (state)
      RD_DRAIN, RD_REQ: o_hreadyout = 1'b0;
      RD_WAIT: begin
        o_hreadyout = i_rd_valid;
        if (i_rd_valid) o_hrdata = i_rd_data;
      end
      default: ;
    endcase
  end

  // The FIFO is always empty while a read request is presented.
  always_comb begin
    o_valid   = 1'b0;
    o_rd0_wr1 = 1'b0;
    o_addr    = '0;
    o_wr_data = '0;
    o_wr_strb = '0;
    if (state == RD_REQ) begin
      o_valid   = 1'b1;
      o_addr    = dp_addr;
      o_wr_strb = '1;
    end else if (count != '0) begin
      o_valid   = 1'b1;
      o_rd0_wr1 = 1'b1;
      o_addr    = fifo_addr[rptr];
      o_wr_data = fifo_data[rptr];
      o_wr_strb = fifo_strb[rptr];
    end
  end

endmodule
